// File: rtl/zero_sequence_generator.sv
// zero_sequence_generator
// Turns queued run lengths into a serial zero-run stream: for each length L
// it emits L zeros followed by a single '1' marker. Lengths enter through a
// small valid/ready FIFO. Runs follow each other with no idle gap.
// Optional build macro: ZERO_SEQ_GEN_STATUS_EN adds the 8-bit runs_done
// output, which counts completed markers.
module zero_sequence_generator #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             NOT_RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
`ifdef ZERO_SEQ_GEN_STATUS_EN
  output logic [7:0]       runs_done,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZEROS = 2'd1,
    MARK  = 2'd2
  } stateT;

  logic [WIDTH-1:0] fifoMem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             pushEn;
  logic             popEn;
  logic [WIDTH-1:0] headLen;

  stateT            state;
  logic [WIDTH-1:0] count;
  logic             serOutQ;
  logic             serValidQ;

  // The extra pointer bit tells full from empty when the indices match.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign headLen   = fifoMem[rdPtr[AW-1:0]];

  // in_ready looks only at full, so a pop on the same edge cannot free a slot.
  assign in_ready  = NOT_RESET & ~fifoFull;
  assign pushEn    = in_valid & in_ready;

  // A new run is taken only from IDLE or from the marker cycle.
  assign popEn     = ENABLE & ~fifoEmpty & ((state == IDLE) | (state == MARK));

  assign ser_out   = serOutQ;
  assign ser_valid = serValidQ;
  assign busy      = (state != IDLE) | ~fifoEmpty;

  // FIFO storage write; the contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem[wrPtr[AW-1:0]] <= in_len;
    end
  end

  // Write pointer advances on each accepted push, even while ENABLE is low.
  always_ff @(posedge clk or negedge NOT_RESET) begin
    if (!NOT_RESET) begin
      wrPtr <= '0;
    end else if (pushEn) begin
      wrPtr <= wrPtr + 1'b1;
    end
  end

  // Read pointer advances when the generator starts a new run.
  always_ff @(posedge clk or negedge NOT_RESET) begin
    if (!NOT_RESET) begin
      rdPtr <= '0;
    end else if (popEn) begin
      rdPtr <= rdPtr + 1'b1;
    end
  end

  // Run FSM with registered serial outputs; a low ENABLE freezes it and blanks ser_valid.
  always_ff @(posedge clk or negedge NOT_RESET) begin
    if (!NOT_RESET) begin
      state     <= IDLE;
      count     <= '0;
      serOutQ   <= 1'b1;
      serValidQ <= 1'b0;
    end else if (!ENABLE) begin
      serValidQ <= 1'b0;
    end else begin
      case (state)
        IDLE, MARK: begin
          if (popEn) begin
            count     <= headLen;
            serValidQ <= 1'b1;
            if (headLen != '0) begin
              state   <= ZEROS;
              serOutQ <= 1'b0;
            end else begin
              state   <= MARK;
              serOutQ <= 1'b1;
            end
          end else begin
            state     <= IDLE;
            serOutQ   <= 1'b1;
            serValidQ <= 1'b0;
          end
        end
        ZEROS: begin
          serValidQ <= 1'b1;
          if (count == WIDTH'(1)) begin
            state   <= MARK;
            serOutQ <= 1'b1;
          end else begin
            count   <= count - 1'b1;
            serOutQ <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          serOutQ   <= 1'b1;
          serValidQ <= 1'b0;
        end
      endcase
    end
  end

`ifdef ZERO_SEQ_GEN_STATUS_EN
  logic [7:0] runsDone;

  // Counts every enabled marker cycle, that is, every exit from MARK. It wraps naturally.
  always_ff @(posedge clk or negedge NOT_RESET) begin
    if (!NOT_RESET) begin
      runsDone <= '0;
    end else if (ENABLE && (state == MARK)) begin
      runsDone <= runsDone + 1'b1;
    end
  end

  assign runs_done = runsDone;
`endif

endmodule
